dram_refresh_arbiter: RTL

- Schedules DRAM refresh and arbitrates the DRAM sequencer between 68000 CPU cycles and CAS-before-RAS refresh cycles on the Mackerel-10 board.
- Contains a refresh interval timer and a pending-refresh counter with urgency escalation.
- Issues one-hot grants to the DRAM sequencer, which performs the actual RAS/CAS/DTACK timing.

---
 rtl/dram_refresh_arbiter_pkg.sv | 23 ++
 rtl/dram_refresh_arbiter_if.sv | 25 ++
 rtl/dram_refresh_arbiter_timer.sv | 33 +++
 rtl/dram_refresh_arbiter.sv | 105 ++++++++++
 4 files changed

// File: rtl/dram_refresh_arbiter_pkg.sv
// Shared types and default constants for the DRAM refresh arbiter.
package dram_pkg;

  // Arbiter ownership of the DRAM sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    REF  = 2'd2
  } state_t;

  // 15.6 us refresh period at a 15 MHz system clock.
  localparam int DEFAULT_REFRESH_INTERVAL = 234;
  localparam int DEFAULT_MAX_PENDING      = 4;

  // Width of the pending-refresh counter for the default backlog depth.
  localparam int DEFAULT_PEND_W = $clog2(DEFAULT_MAX_PENDING + 1);

  // Width of a counter that must hold 0..interval-1 (at least one bit).
  function automatic int timer_width(input int interval);
    return (interval > 1) ? $clog2(interval) : 1;
  endfunction

endpackage

// File: rtl/dram_refresh_arbiter_if.sv
// Handshake bundle between the arbiter, the CPU decode and the DRAM sequencer.
interface dram_refresh_arbiter_if #(
  parameter int PEND_W = 3
);
  logic              REF_EN;
  logic              CPU_REQ;
  logic              REF_DONE;
  logic              GRANT_CPU;
  logic              GRANT_REF;
  logic [PEND_W-1:0] REF_PENDING;
  logic              REF_OVF;
  logic              BUSY;

  // Arbiter side.
  modport slave (
    input  REF_EN, CPU_REQ, REF_DONE,
    output GRANT_CPU, GRANT_REF, REF_PENDING, REF_OVF, BUSY
  );

  // Requester / sequencer side.
  modport master (
    output REF_EN, CPU_REQ, REF_DONE,
    input  GRANT_CPU, GRANT_REF, REF_PENDING, REF_OVF, BUSY
  );
endinterface

// File: rtl/dram_refresh_arbiter_timer.sv
// Refresh interval timer: counts 0..REFRESH_INTERVAL-1 while enabled and
// pulses tick for one clock on the last count.
module dram_refresh_timer
  import dram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL
) (
  input  logic CLK,
  input  logic RST,
  input  logic REF_EN,
  output logic tick
);
  localparam int CW = timer_width(REFRESH_INTERVAL);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_INTERVAL - 1);

  logic [CW-1:0] count_reg;

  // Interval counter; parked at zero whenever refresh timing is disabled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_reg <= '0;
    end else if (!REF_EN) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = REF_EN && (count_reg == LAST);

endmodule

// File: rtl/dram_refresh_arbiter.sv
// Refresh scheduler and CPU/refresh arbiter for the DRAM sequencer.
// Grants are decoded from the registered state, so every decision takes
// effect one clock after the condition that caused it.
module dram_refresh_arbiter
  import dram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
  parameter int MAX_PENDING      = DEFAULT_MAX_PENDING
) (
  input  logic                   CLK,
  input  logic                   RST,
  dram_refresh_arbiter_if.slave  bus
);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  logic              tick;
  state_t            state_reg, state_next;
  logic [PEND_W-1:0] pending_reg, pending_next;
  logic              ovf_reg, ovf_next;
  logic              grant_cpu, grant_ref, busy;

  dram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .REF_EN (bus.REF_EN),
    .tick   (tick)
  );

  // Backlog bookkeeping: ticks add, completions remove, saturate at full
  // backlog (flagging the lost tick) and never underflow.
  always_comb begin
    pending_next = pending_reg;
    ovf_next     = ovf_reg;
    if (tick && !bus.REF_DONE) begin
      if (pending_reg == PEND_MAX) begin
        ovf_next = 1'b1;
      end else begin
        pending_next = pending_reg + 1'b1;
      end
    end else if (!tick && bus.REF_DONE) begin
      if (pending_reg != '0) begin
        pending_next = pending_reg - 1'b1;
      end
    end
  end

  // Next-state selection and grant decode; a full backlog beats a waiting CPU.
  always_comb begin
    state_next = state_reg;
    grant_cpu  = 1'b0;
    grant_ref  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.CPU_REQ && (pending_reg == PEND_MAX)) begin
          state_next = REF;
        end else if (bus.CPU_REQ) begin
          state_next = CPU;
        end else if (pending_reg != '0) begin
          state_next = REF;
        end
      end
      CPU: begin
        grant_cpu = 1'b1;
        busy      = 1'b1;
        if (!bus.CPU_REQ) begin
          state_next = IDLE;
        end
      end
      REF: begin
        grant_ref = 1'b1;
        busy      = 1'b1;
        if (bus.REF_DONE) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, backlog and overflow registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      ovf_reg     <= ovf_next;
    end
  end

  assign bus.GRANT_CPU   = grant_cpu;
  assign bus.GRANT_REF   = grant_ref;
  assign bus.BUSY        = busy;
  assign bus.REF_PENDING = pending_reg;
  assign bus.REF_OVF     = ovf_reg;

endmodule
